// File: rtl/piso_stream_serializer.sv
// rtl/piso_stream_serializer.sv - parallel-in/serial-out shifter with valid/ready word load
// A word reloads on the same edge that consumes the last bit, so consecutive words stream gap-free.
module piso_stream_serializer #(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             first_bit,
  output logic             last_bit
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shifted;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             head_bit;
  logic             at_last;
  logic             accept;

  // Direction only changes which end feeds the line and which way the word moves.
  generate
    if (MSB_FIRST) begin : g_msb
      assign head_bit      = shreg[WIDTH-1];
      assign shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign head_bit      = shreg[0];
      assign shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
    end
  endgenerate

  assign at_last      = (cnt == LAST);
  assign in_ready     = !busy || (shift_en && at_last);
  assign accept       = in_valid && in_ready;

  assign serial_out   = busy ? head_bit : IDLE_LEVEL;
  assign serial_valid = busy;
  assign first_bit    = busy && (cnt == '0);
  assign last_bit     = busy && at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (accept) begin
      shreg <= parallel_in;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (busy && shift_en) begin
      if (at_last) begin
        busy <= 1'b0;
      end else begin
        shreg <= shreg_shifted;
        cnt   <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piso_stream_serializer.sv
// tb/tb_piso_stream_serializer.sv - directed self-checking bench for piso_stream_serializer
// Two instances (MSB-first and LSB-first) share one set of inputs.
module tb_piso_stream_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] parallel_in = 4'h0;
  logic       shift_en = 1'b1;

  logic m_ready, m_out, m_valid, m_first, m_last;
  logic l_ready, l_out, l_valid, l_first, l_last;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  piso_stream_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_ready),
    .parallel_in(parallel_in), .shift_en(shift_en), .serial_out(m_out),
    .serial_valid(m_valid), .first_bit(m_first), .last_bit(m_last)
  );

  piso_stream_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_ready),
    .parallel_in(parallel_in), .shift_en(shift_en), .serial_out(l_out),
    .serial_valid(l_valid), .first_bit(l_first), .last_bit(l_last)
  );

  // Present a word for one cycle; returns just after the accepting edge.
  task automatic send(input logic [3:0] w);
    in_valid    = 1'b1;
    parallel_in = w;
    @(posedge clk); #1;
    in_valid    = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if ({m_out, m_valid, m_first, m_last, m_ready} !== 5'b00001)
      $display("FAIL reset_msb got=%b want=00001", {m_out, m_valid, m_first, m_last, m_ready});
    else pass_cnt++;
    total_cnt++; if ({l_out, l_valid, l_first, l_last, l_ready} !== 5'b00001)
      $display("FAIL reset_lsb got=%b want=00001", {l_out, l_valid, l_first, l_last, l_ready});
    else pass_cnt++;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_msb_first();
    logic [3:0] exp_bits;
    exp_bits = 4'b1011;
    shift_en = 1'b1;
    send(4'b1011);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total_cnt++; if ({m_out, m_valid, m_first, m_last} !== {exp_bits[3-i], 1'b1, i == 0, i == 3})
        $display("FAIL msb_bit%0d got=%b want=%b", i + 1, {m_out, m_valid, m_first, m_last},
                 {exp_bits[3-i], 1'b1, i == 0, i == 3});
      else pass_cnt++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    total_cnt++; if ({m_out, m_valid} !== 2'b00)
      $display("FAIL msb_idle_after got=%b want=00", {m_out, m_valid});
    else pass_cnt++;
  endtask

  task automatic test_lsb_first();
    logic [3:0] exp_bits;
    exp_bits = 4'b1011;
    @(posedge clk); #1;
    send(4'b1011);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total_cnt++; if ({l_out, l_ready} !== {exp_bits[i], i == 3})
        $display("FAIL lsb_bit%0d got out/ready=%b want=%b", i + 1, {l_out, l_ready}, {exp_bits[i], i == 3});
      else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_bits;
    exp_bits = 8'b1011_0110;
    @(posedge clk); #1;
    in_valid = 1'b1;
    parallel_in = 4'b1011;
    @(posedge clk); #1;
    parallel_in = 4'b0110;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total_cnt++; if ({m_out, m_valid} !== {exp_bits[7-i], 1'b1})
        $display("FAIL b2b_bit%0d got=%b want=%b", i + 1, {m_out, m_valid}, {exp_bits[7-i], 1'b1});
      else pass_cnt++;
      @(posedge clk); #1;
      if (i == 3) in_valid = 1'b0;
    end
    @(negedge clk);
    total_cnt++; if (m_valid !== 1'b0)
      $display("FAIL b2b_end got=%b want=0", m_valid);
    else pass_cnt++;
  endtask

  task automatic test_slow_strobe();
    logic [3:0] exp_bits;
    exp_bits = 4'b1001;
    @(posedge clk); #1;
    shift_en = 1'b0;
    send(4'b1001);
    for (int c = 0; c < 12; c++) begin
      shift_en = ((c % 3) == 2);
      @(negedge clk);
      total_cnt++; if ({m_out, m_valid, m_first} !== {exp_bits[3 - c/3], 1'b1, c < 3})
        $display("FAIL slow_cycle%0d got=%b want=%b", c, {m_out, m_valid, m_first},
                 {exp_bits[3 - c/3], 1'b1, c < 3});
      else pass_cnt++;
      @(posedge clk); #1;
    end
    shift_en = 1'b1;
    @(negedge clk);
    total_cnt++; if (m_valid !== 1'b0)
      $display("FAIL slow_end got=%b want=0", m_valid);
    else pass_cnt++;
  endtask

  task automatic test_load_while_busy();
    logic [7:0] exp_bits;
    exp_bits = 8'b1011_1111;
    @(posedge clk); #1;
    shift_en = 1'b1;
    send(4'b1011);
    in_valid = 1'b1;
    parallel_in = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total_cnt++; if ({m_out, m_ready} !== {exp_bits[7-i], i == 3 || i == 7})
        $display("FAIL busy_load_bit%0d got out/ready=%b want=%b", i + 1, {m_out, m_ready},
                 {exp_bits[7-i], i == 3 || i == 7});
      else pass_cnt++;
      @(posedge clk); #1;
      if (i == 3) in_valid = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] exp_bits;
    @(posedge clk); #1;
    send(4'b1010);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total_cnt++; if (m_out !== (i == 0))
        $display("FAIL rst_pre_bit%0d got=%b want=%b", i + 1, m_out, i == 0);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    #1 rst_n = 1'b0;
    #1;
    total_cnt++; if ({m_out, m_valid, m_ready} !== 3'b001)
      $display("FAIL rst_async got=%b want=001", {m_out, m_valid, m_ready});
    else pass_cnt++;
    @(posedge clk); #1 rst_n = 1'b1;
    exp_bits = 4'b1100;
    send(4'b1100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total_cnt++; if ({m_out, m_first} !== {exp_bits[3-i], i == 0})
        $display("FAIL rst_reload_bit%0d got=%b want=%b", i + 1, {m_out, m_first}, {exp_bits[3-i], i == 0});
      else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_slow_strobe();
    test_load_while_busy();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
